// File: rtl/fifo_rd_arbiter.sv
// Purpose: round-robin read scheduler sharing one word port between NUM_CH registered-read FIFOs, frame-granular grants closed by EOF_MARK.
// Latency: request seen in IDLE -> read strobe next cycle -> word on out_data 3 cycles after the request; 1 word per 3 cycles steady state.
// Backpressure: out_ready=0 holds the word in OUT and stalls further reads; an empty granted FIFO mid-frame aborts after TIMEOUT cycles.
module fifo_rd_arbiter #(
    parameter int                NUM_CH   = 4,
    parameter int                WIDTH    = 16,
    parameter logic [WIDTH-1:0]  EOF_MARK = 16'hF1FA,
    parameter int                TIMEOUT  = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         fifo_empty,
    input  logic [NUM_CH*WIDTH-1:0]   fifo_rd_data,
    output logic [NUM_CH-1:0]         fifo_rd_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [2:0]                out_ch,
    output logic                      out_last,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam logic [2:0]  LAST_CH = 3'(NUM_CH - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WT,
        S_OUT
    } state_t;

    state_t            state;
    logic [2:0]        ptr;
    logic [2:0]        gnt;
    logic [15:0]       to_cnt;

    logic [NUM_CH-1:0] req;
    logic              any_req;
    logic [2:0]        pick;
    logic [2:0]        nxt_ptr;
    logic              rd_fire;

    // Per-channel views padded to 8 entries so the 3-bit grant index is always in range.
    logic [7:0]        empty8;
    logic [WIDTH-1:0]  data8 [8];

    for (genvar i = 0; i < 8; i++) begin : g_ch
        if (i < NUM_CH) begin : g_used
            assign empty8[i] = fifo_empty[i];
            assign data8[i]  = fifo_rd_data[i*WIDTH +: WIDTH];
            // Read strobe is combinational so it can never fire against an empty flag seen in the same cycle.
            assign fifo_rd_en[i] = rd_fire && (gnt == 3'(i));
        end else begin : g_pad
            assign empty8[i] = 1'b1;
            assign data8[i]  = '0;
        end
    end

    assign req     = ~fifo_empty;
    assign any_req = |req;
    assign rd_fire = (state == S_RD) && !empty8[gnt];
    assign nxt_ptr = (gnt == LAST_CH) ? 3'd0 : gnt + 3'd1;

    // Round-robin pick: lowest requester at or above ptr, otherwise wrap to the lowest requester overall.
    always_comb begin
        pick = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) pick = 3'(i);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i] && (3'(i) >= ptr)) pick = 3'(i);
        end
    end

    // Grant FSM with registered output word, status and timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= '0;
            gnt         <= '0;
            to_cnt      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_ch      <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable && any_req) begin
                        gnt    <= pick;
                        to_cnt <= '0;
                        busy   <= 1'b1;
                        state  <= S_RD;
                    end
                end
                S_RD: begin
                    // A word arriving on the last allowed cycle still wins over the abort.
                    if (!empty8[gnt]) begin
                        to_cnt <= '0;
                        state  <= S_WT;
                    end else if (to_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        ptr         <= nxt_ptr;
                        to_cnt      <= '0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                S_WT: begin
                    out_data  <= data8[gnt];
                    out_ch    <= gnt;
                    out_last  <= (data8[gnt] == EOF_MARK);
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            ptr   <= nxt_ptr;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Purpose: self-checking bench for fifo_rd_arbiter with behavioural FIFOs and a frame-level round-robin model.
// Latency: checks the 3-cycle first-word latency, 3-cycle word spacing and the TIMEOUT abort point.
// Backpressure: out_ready is held high, held low or randomized per cycle by a single driver process.
module tb_fifo_rd_arbiter;

    localparam int          NCH = 4;
    localparam int          TO  = 8;
    localparam logic [15:0] EOF = 16'hF1FA;

    typedef struct packed {
        logic [2:0]  ch;
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [NCH-1:0]    fifo_empty;
    logic [NCH*16-1:0] fifo_rd_data;
    logic [NCH-1:0]    fifo_rd_en;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic [2:0]        out_ch;
    logic              out_last;
    logic              busy;
    logic              err_timeout;

    fifo_rd_arbiter #(
        .NUM_CH  (NCH),
        .WIDTH   (16),
        .EOF_MARK(EOF),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_last    (out_last),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          viol  = 0;
    int          mptr  = 0;
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
    beat_t       cap[$];
    beat_t       exp_q[$];
    logic [15:0] mq [NCH][$];
    logic [15:0] mem [NCH][256];
    int          wp [NCH];
    int          rp [NCH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural FIFOs: pop on the edge where rd_en was high, data valid the following cycle.
    initial begin
        logic [NCH-1:0] rd_snap;
        fifo_empty   = '1;
        fifo_rd_data = '0;
        forever begin
            @(posedge clk);
            rd_snap = fifo_rd_en;
            #1;
            for (int i = 0; i < NCH; i++) begin
                if (rd_snap[i] && rp[i] != wp[i]) begin
                    fifo_rd_data[i*16 +: 16] = mem[i][rp[i]];
                    rp[i]++;
                end
                fifo_empty[i] = (rp[i] == wp[i]);
            end
            @(negedge clk);
            #1;
            for (int i = 0; i < NCH; i++) fifo_empty[i] = (rp[i] == wp[i]);
        end
    end

    // Downstream: drive out_ready per mode and record each word that will be handed off at the next edge.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if (out_valid && out_ready && !rst) cap.push_back('{out_ch, out_data, out_last});
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input int ch, input logic [15:0] w);
        mem[ch][wp[ch]] = w;
        wp[ch]++;
    endtask

    task automatic load(input int ch, input logic [15:0] w);
        push(ch, w);
        mq[ch].push_back(w);
    endtask

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w == EOF) w = 16'h0001;
        return w;
    endfunction

    // Frame-level model: pick first non-empty channel from mptr, emit its words up to the end marker.
    task automatic model_drain();
        int          ch;
        logic [15:0] w;
        bit          any;
        forever begin
            any = 0;
            for (int i = 0; i < NCH; i++) if (mq[i].size() != 0) any = 1;
            if (!any) break;
            ch = mptr;
            while (mq[ch].size() == 0) ch = (ch + 1) % NCH;
            do begin
                w = mq[ch].pop_front();
                exp_q.push_back('{3'(ch), w, w == EOF});
            end while (w != EOF && mq[ch].size() != 0);
            mptr = (ch + 1) % NCH;
        end
    endtask

    task automatic wait_idle(input bit need_empty, input int budget, output bit ok);
        int quiet;
        quiet = 0;
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if ($countones(fifo_rd_en) > 1 || (fifo_rd_en & fifo_empty) != '0) viol++;
            if (!busy && !out_valid && (!need_empty || fifo_empty == '1)) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        ready_mode = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_timeout); end
        n_cmp++; if (fifo_rd_en !== '0)    begin n_bad++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
        n_cmp++; if (out_data !== '0)      begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_cmp++; if (out_ch !== '0)        begin n_bad++; $display("FAIL reset_out_ch got %0d want 0", out_ch); end
        n_cmp++; if (out_last !== 1'b0)    begin n_bad++; $display("FAIL reset_out_last got %b want 0", out_last); end
        rst = 1'b0;
        mptr = 0;
    endtask

    task automatic test_single_frame();
        logic [15:0] words [3];
        int          base, ebase;
        bit          ok;
        words[0] = 16'h0011; words[1] = 16'h0022; words[2] = EOF;
        enable = 1'b1;
        ready_mode = 0;
        @(negedge clk);
        base = cap.size(); ebase = exp_q.size();
        for (int i = 0; i < 3; i++) load(0, words[i]);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++; if (fifo_rd_en !== 4'b0001) begin n_bad++; $display("FAIL single_rd_en_c1 got %b want 0001", fifo_rd_en); end
            end
            n_cmp++;
            if (out_valid !== (k % 3 == 0 && k <= 9)) begin
                n_bad++; $display("FAIL single_valid_c%0d got %b want %b", k, out_valid, (k % 3 == 0 && k <= 9));
            end
            if (k % 3 == 0 && k <= 9) begin
                n_cmp++;
                if (out_data !== words[k/3-1] || out_ch !== 3'd0 || out_last !== (k == 9)) begin
                    n_bad++; $display("FAIL single_word_c%0d got %h ch%0d last%b want %h ch0 last%b",
                                      k, out_data, out_ch, out_last, words[k/3-1], (k == 9));
                end
            end
            n_cmp++;
            if (busy !== (k <= 9)) begin n_bad++; $display("FAIL single_busy_c%0d got %b want %b", k, busy, (k <= 9)); end
        end
        wait_idle(1, 100, ok);
        model_drain();
        n_cmp++; if (!ok || cap.size() - base != 3) begin n_bad++; $display("FAIL single_count got %0d want 3", cap.size() - base); end
    endtask

    task automatic test_round_robin();
        int base, ebase, nf;
        bit ok;
        int want_ch [4];
        want_ch[0] = 0; want_ch[1] = 1; want_ch[2] = 3; want_ch[3] = 0;
        @(negedge clk); rst = 1'b1; enable = 1'b0;
        @(negedge clk); rst = 1'b0; mptr = 0; viol = 0;
        base = cap.size(); ebase = exp_q.size();
        load(0, rnd_word()); load(0, EOF);
        load(1, rnd_word()); load(1, EOF);
        load(3, rnd_word()); load(3, EOF);
        @(negedge clk); enable = 1'b1; ready_mode = 1;
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cap.size() >= base + 2) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_first_frame got %0d words want 2", cap.size() - base); end
        load(0, rnd_word()); load(0, EOF);
        wait_idle(1, 2000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_drain_timeout busy=%b", busy); end
        model_drain();
        n_cmp++; if (cap.size() - base != exp_q.size() - ebase) begin
            n_bad++; $display("FAIL rr_count got %0d want %0d", cap.size() - base, exp_q.size() - ebase);
        end
        for (int i = 0; i < exp_q.size() - ebase && base + i < cap.size(); i++) begin
            n_cmp++; if (cap[base+i] !== exp_q[ebase+i]) begin
                n_bad++; $display("FAIL rr_beat%0d got ch%0d %h last%b want ch%0d %h last%b", i,
                    cap[base+i].ch, cap[base+i].data, cap[base+i].last, exp_q[ebase+i].ch, exp_q[ebase+i].data, exp_q[ebase+i].last);
            end
        end
        nf = 0;
        for (int i = base; i < cap.size(); i++) begin
            if (cap[i].last && nf < 4) begin
                n_cmp++; if (cap[i].ch !== 3'(want_ch[nf])) begin
                    n_bad++; $display("FAIL rr_frame%0d_ch got %0d want %0d", nf, cap[i].ch, want_ch[nf]);
                end
                nf++;
            end
        end
        n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rr_rd_en_rules got %0d violations want 0", viol); end
    endtask

    task automatic test_random_traffic();
        int base, ebase, len, ch;
        bit ok;
        enable = 1'b0; viol = 0;
        @(negedge clk);
        base = cap.size(); ebase = exp_q.size();
        for (int f = 0; f < 12; f++) begin
            ch = $urandom_range(0, NCH - 1);
            len = $urandom_range(1, 4);
            for (int j = 0; j < len - 1; j++) load(ch, rnd_word());
            load(ch, EOF);
        end
        @(negedge clk); enable = 1'b1; ready_mode = 1;
        wait_idle(1, 3000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand_drain_timeout busy=%b", busy); end
        model_drain();
        n_cmp++; if (cap.size() - base != exp_q.size() - ebase) begin
            n_bad++; $display("FAIL rand_count got %0d want %0d", cap.size() - base, exp_q.size() - ebase);
        end
        for (int i = 0; i < exp_q.size() - ebase && base + i < cap.size(); i++) begin
            n_cmp++; if (cap[base+i] !== exp_q[ebase+i]) begin
                n_bad++; $display("FAIL rand_beat%0d got ch%0d %h last%b want ch%0d %h last%b", i,
                    cap[base+i].ch, cap[base+i].data, cap[base+i].last, exp_q[ebase+i].ch, exp_q[ebase+i].data, exp_q[ebase+i].last);
            end
        end
        n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL rand_rd_en_rules got %0d violations want 0", viol); end
    endtask

    task automatic test_backpressure();
        int base, ebase, hits;
        bit ok;
        ready_mode = 2;
        @(negedge clk);
        base = cap.size(); ebase = exp_q.size();
        load(2, 16'h1234); load(2, EOF);
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_valid_timeout out_valid=%b", out_valid); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h1234 || fifo_rd_en !== '0) begin
                n_bad++; $display("FAIL bp_hold_c%0d got valid%b %h rd_en%b want valid1 1234 rd_en0000", k, out_valid, out_data, fifo_rd_en);
            end
        end
        ready_mode = 0;
        wait_idle(1, 100, ok);
        model_drain();
        hits = 0;
        for (int i = base; i < cap.size(); i++) if (cap[i].data == 16'h1234) hits++;
        n_cmp++; if (!ok || hits != 1) begin n_bad++; $display("FAIL bp_accept_once got %0d want 1", hits); end
        for (int i = 0; i < exp_q.size() - ebase && base + i < cap.size(); i++) begin
            n_cmp++; if (cap[base+i] !== exp_q[ebase+i]) begin
                n_bad++; $display("FAIL bp_beat%0d got %h want %h", i, cap[base+i].data, exp_q[ebase+i].data);
            end
        end
    endtask

    task automatic test_timeout();
        int  base, ebase, pulses;
        bit  ok;
        ready_mode = 0; enable = 1'b1;
        @(negedge clk);
        push(1, 16'h00AA);
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid && out_data == 16'h00AA) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_first_word_timeout out_valid=%b", out_valid); end
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (err_timeout) pulses++;
            n_cmp++; if (err_timeout !== (k == 9)) begin
                n_bad++; $display("FAIL to_err_c%0d got %b want %b", k, err_timeout, (k == 9));
            end
            n_cmp++; if (busy !== (k <= 8) || fifo_rd_en !== '0) begin
                n_bad++; $display("FAIL to_busy_c%0d got busy%b rd_en%b want busy%b rd_en0000", k, busy, fifo_rd_en, (k <= 8));
            end
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL to_pulse_count got %0d want 1", pulses); end
        mptr = 2;
        enable = 1'b0;
        base = cap.size(); ebase = exp_q.size();
        load(0, EOF); load(3, EOF);
        @(negedge clk); enable = 1'b1;
        wait_idle(1, 200, ok);
        model_drain();
        n_cmp++; if (!ok || cap.size() - base != 2) begin n_bad++; $display("FAIL to_resume_count got %0d want 2", cap.size() - base); end
        n_cmp++; if (cap.size() > base && cap[base].ch !== 3'd3) begin
            n_bad++; $display("FAIL to_resume_first_ch got %0d want 3", cap[base].ch);
        end
        // Refill on the last allowed empty cycle: the read must win.
        @(negedge clk);
        push(1, 16'h00BB);
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid && out_data == 16'h00BB) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL to2_first_word_timeout out_valid=%b", out_valid); end
        base = cap.size();
        pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (err_timeout) pulses++;
            if (k == 8) push(1, EOF);
        end
        n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL to2_no_error got %0d pulses want 0", pulses); end
        wait_idle(1, 100, ok);
        n_cmp++; if (!ok || cap.size() == 0 || cap[cap.size()-1] !== beat_t'{3'd1, EOF, 1'b1}) begin
            n_bad++; $display("FAIL to2_eof_word got %0d new words want ch1 f1fa last", cap.size() - base);
        end
        mptr = 2;
    endtask

    task automatic test_enable_mid_frame();
        int  base, ebase, grants;
        bit  ok;
        logic [15:0] a, b;
        a = rnd_word(); b = rnd_word();
        ready_mode = 0; enable = 1'b1;
        @(negedge clk);
        base = cap.size(); ebase = exp_q.size();
        load(0, a); load(0, b); load(0, EOF);
        model_drain();
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cap.size() > base) begin ok = 1; break; end
        end
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL en_first_word_timeout got %0d words", cap.size() - base); end
        enable = 1'b0;
        load(3, EOF);
        wait_idle(0, 100, ok);
        n_cmp++; if (!ok || cap.size() - base != 3) begin n_bad++; $display("FAIL en_frame_complete got %0d words want 3", cap.size() - base); end
        n_cmp++; if (cap.size() - base >= 3 && (cap[base+2].data !== EOF || cap[base+1].data !== b || cap[base+2].ch !== 3'd0)) begin
            n_bad++; $display("FAIL en_frame_words got %h %h ch%0d want %h f1fa ch0", cap[base+1].data, cap[base+2].data, cap[base+2].ch, b);
        end
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy || fifo_rd_en != '0) grants++;
        end
        n_cmp++; if (grants != 0) begin n_bad++; $display("FAIL en_blocked got %0d busy cycles want 0", grants); end
        enable = 1'b1;
        wait_idle(1, 100, ok);
        model_drain();
        n_cmp++; if (!ok || cap.size() - base != exp_q.size() - ebase) begin
            n_bad++; $display("FAIL en_total got %0d want %0d", cap.size() - base, exp_q.size() - ebase);
        end
        for (int i = 0; i < exp_q.size() - ebase && base + i < cap.size(); i++) begin
            n_cmp++; if (cap[base+i] !== exp_q[ebase+i]) begin
                n_bad++; $display("FAIL en_beat%0d got ch%0d %h want ch%0d %h", i, cap[base+i].ch, cap[base+i].data, exp_q[ebase+i].ch, exp_q[ebase+i].data);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int  base, ebase;
        bit  ok;
        ready_mode = 0; enable = 1'b1;
        @(negedge clk);
        load(2, EOF);
        wait_idle(1, 100, ok);
        model_drain();
        ready_mode = 2;
        push(3, 16'h5555); push(3, EOF);
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        n_cmp++; if (!ok || out_data !== 16'h5555 || out_ch !== 3'd3) begin
            n_bad++; $display("FAIL rst_pre_word got %h ch%0d want 5555 ch3", out_data, out_ch);
        end
        rst = 1'b1; enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_rd_en !== '0) begin
            n_bad++; $display("FAIL rst_mid_state got valid%b busy%b rd_en%b want 0 0 0000", out_valid, busy, fifo_rd_en);
        end
        rst = 1'b0;
        mptr = 0;
        base = cap.size(); ebase = exp_q.size();
        load(0, EOF);
        mq[3].push_back(EOF);
        ready_mode = 0;
        @(negedge clk); enable = 1'b1;
        wait_idle(1, 200, ok);
        model_drain();
        n_cmp++; if (!ok || cap.size() - base != 2) begin n_bad++; $display("FAIL rst_after_count got %0d want 2", cap.size() - base); end
        n_cmp++; if (cap.size() > base && cap[base].ch !== 3'd0) begin
            n_bad++; $display("FAIL rst_ptr_cleared got first ch%0d want ch0", cap[base].ch);
        end
        for (int i = 0; i < exp_q.size() - ebase && base + i < cap.size(); i++) begin
            n_cmp++; if (cap[base+i] !== exp_q[ebase+i]) begin
                n_bad++; $display("FAIL rst_beat%0d got ch%0d %h want ch%0d %h", i, cap[base+i].ch, cap[base+i].data, exp_q[ebase+i].ch, exp_q[ebase+i].data);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_random_traffic();
        test_backpressure();
        test_timeout();
        test_enable_mid_frame();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Round-robin read scheduler that shares one downstream 16-bit word port between NUM_CH `sync_fifo2`-style buffers. It grants one FIFO at a time and drives that FIFO's read enable. Every word read is forwarded over a valid/ready output, and the grant is held until the frame-end marker 0xF1FA has been delivered. It sits between the per-source spike/event FIFOs and the shared processing datapath.

## Interface
- NUM_CH, 4: number of requester FIFOs, 2..8.
- WIDTH, 16: word width; must be 16 because the end-marker compare is 16 bits.
- EOF_MARK, 16'hF1FA: frame-end word; it is forwarded and closes the grant.
- TIMEOUT, 1024: cycles a granted FIFO may stay empty mid-frame before abort, 1..65535.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high; it takes effect on the rising edge where rst=1.
- enable  in  1  permits new grants; it does not interrupt a frame in progress.
- fifo_empty  in  NUM_CH  per-channel empty flag, bit i = channel i.
- fifo_rd_data  in  NUM_CH*WIDTH  per-channel registered read data, channel i at [i*WIDTH +: WIDTH].
- fifo_rd_en  out  NUM_CH  per-channel read strobe; at most one bit is high in any cycle.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  downstream accepts the word when out_valid & out_ready.
- out_data  out  WIDTH  forwarded word.
- out_ch  out  3  channel index of out_data.
- out_last  out  1  out_data == EOF_MARK.
- busy  out  1  a grant is held (state != IDLE).
- err_timeout  out  1  one-cycle pulse when a frame is aborted on timeout.

## Operation
- FIFO read model: data appears on fifo_rd_data in the cycle after the cycle in which fifo_rd_en is high.
- States:
  - IDLE:
    - If enable=1 and any fifo_empty bit is 0, register a grant g and go to RD.
    - g is the first non-empty channel found searching from ptr upward, wrapping modulo NUM_CH.
  - RD:
    - If fifo_empty[g]=0: assert fifo_rd_en[g] for this cycle only, clear the timeout counter, go to WT.
    - If fifo_empty[g]=1: increment the timeout counter and stay in RD.
    - When the counter reaches TIMEOUT-1: pulse err_timeout, set ptr=(g+1) mod NUM_CH, go to IDLE.
  - WT:
    - Load out_data <= fifo_rd_data[g], out_ch <= g, out_last <= (data==EOF_MARK).
    - Set out_valid=1 and go to OUT.
  - OUT:
    - Hold out_data, out_ch and out_last stable while out_ready=0.
    - On handshake, clear out_valid.
    - If out_last=1: set ptr=(g+1) mod NUM_CH and go to IDLE. Otherwise go to RD.
- Only one read is in flight at a time, so no skid buffer is needed and no word is ever dropped.
- enable=0 only blocks the IDLE→RD transition. A frame already granted always completes or times out.
- A frame whose first word is EOF_MARK is a legal one-word frame.
- fifo_rd_en is never asserted while fifo_empty of the same channel is 1.

## Timing
- Reset values: state=IDLE, ptr=0, g=0, counter=0. All outputs are 0: fifo_rd_en, out_valid, out_data, out_ch, out_last, busy, err_timeout.
- rst=1 mid-frame returns to IDLE on that edge. out_valid drops and any word not yet handed off is discarded.
- Latency, with out_ready=1 and data present:
  - Cycle 0: IDLE, request seen.
  - Cycle 1: RD, rd_en=1.
  - Cycle 2: WT.
  - Cycle 3: out_valid=1.
- Steady-state throughput is 1 word per 3 cycles. Each cycle with out_ready=0 adds 1 cycle.
- An out_valid=1 with out_last=1 accepted in cycle n allows a new grant decision in IDLE in cycle n+1, so the arbitration gap is 1 cycle.
- busy is high in RD, WT and OUT, and low in IDLE.
- err_timeout is high in the single cycle of the RD→IDLE transition. It is registered, so it is seen in the first IDLE cycle.
- If the granted channel becomes non-empty in the same cycle the counter reaches TIMEOUT-1, the read wins and no timeout is raised.
- The timeout counter is 16 bits wide and clears on every grant and every read.

## Test plan
- Reset and single frame:
  - Stimulus: rst 2 cycles, then ch0 holds 0x0011, 0x0022, 0xF1FA; out_ready=1.
  - Response: out_data 0x0011, 0x0022, 0xF1FA on cycles 3, 6, 9 after the request; out_last only on 0xF1FA; out_ch=0; busy low after.
- Round robin:
  - Stimulus: ch0, ch1 and ch3 each hold a two-word frame ending in 0xF1FA; ch2 empty.
  - Response: frames emitted in order ch0, ch1, ch3, with no interleaving inside a frame. A later new frame on ch0 is granted after ch3.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while out_valid=1 carrying 0x1234.
  - Response: out_data stays 0x1234; no fifo_rd_en pulses; the word is accepted exactly once.
- Mid-frame starvation and timeout:
  - Stimulus: TIMEOUT=8; ch1 delivers 0x00AA, then stays empty.
  - Response: err_timeout pulses once, 8 RD cycles after the 0x00AA handshake; the next grant starts search at ch2.
  - Stimulus (second case): ch1 refills at cycle 7.
  - Response: no error.
- enable and reset mid-frame:
  - Stimulus: enable=0 after the first word of a ch0 frame.
  - Response: the frame completes, then no new grant while enable=0.
  - Stimulus (second case): rst=1 in OUT.
  - Response: next cycle has out_valid=0, busy=0, ptr=0.
